// File: rtl/msm_slot_pkg.sv
// Shared slot-tracking definitions for the MSM pipeline.
// Slot count default, derived ID width and the slot ID type.
package msm_slot_pkg;

  localparam int SLOT_N   = 16;
  localparam int SLOT_IDW = $clog2(SLOT_N);

  typedef logic [SLOT_IDW-1:0] slot_id_t;

endpackage

// File: rtl/lowest_zero_onehot.sv
// Lowest-zero priority finder: one-hot mask of the lowest clear bit in i_vec.
// An all-ones input yields an all-zero mask.
module lowest_zero_onehot #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_vec,
  output logic [N-1:0] o_onehot
);

  localparam logic [N-1:0] ONE = N'(1);

  // Adding one ripples through the trailing ones and sets the lowest zero.
  assign o_onehot = ~i_vec & (i_vec + ONE);

endmodule

// File: rtl/onehot2bin.sv
// One-hot to binary encoder; an all-zero input encodes to 0.
module onehot2bin #(
  parameter int N   = 16,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_onehot,
  output logic [IDW-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < N; i++) begin
      if (i_onehot[i]) begin
        o_bin = o_bin | IDW'(i);
      end else begin
        o_bin = o_bin;
      end
    end
  end

endmodule

// File: rtl/slot_freelist.sv
// Slot free-list: offers the lowest free slot ID over valid/ready and
// takes releases from the completion side; tracks occupancy and illegal releases.
module slot_freelist
  import msm_slot_pkg::*;
#(
  parameter  int N   = SLOT_N,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           alloc_valid,
  output logic [IDW-1:0] alloc_id,
  input  logic           alloc_ready,
  input  logic           rel_valid,
  input  logic [IDW-1:0] rel_id,
  output logic [IDW:0]   busy_cnt,
  output logic           full,
  output logic           empty,
  output logic           err
);

  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [IDW:0] FULL = (IDW+1)'(N);

  logic [N-1:0]   r_busy;
  logic           r_offer_v;
  logic [IDW-1:0] r_offer_id;
  logic [IDW:0]   r_cnt;
  logic           r_full;
  logic           r_empty;
  logic           r_err;

  logic           w_acc;
  logic           w_rel_ok;
  logic           w_hold;
  logic [N-1:0]   w_acc_oh;
  logic [N-1:0]   w_rel_oh;
  logic [N-1:0]   w_busy_n;
  logic [N-1:0]   w_low_oh;
  logic [IDW-1:0] w_low_id;
  logic           w_any_free;
  logic [IDW:0]   w_cnt_n;

  // The offered slot is not yet busy, so releasing it is rejected here too.
  assign w_acc      = r_offer_v & alloc_ready;
  assign w_rel_ok   = rel_valid & r_busy[rel_id];
  assign w_hold     = r_offer_v & ~w_acc;
  assign w_acc_oh   = w_acc    ? (ONE << r_offer_id) : '0;
  assign w_rel_oh   = w_rel_ok ? (ONE << rel_id)     : '0;
  assign w_busy_n   = (r_busy | w_acc_oh) & ~w_rel_oh;
  assign w_any_free = |(~w_busy_n);
  assign w_cnt_n    = r_cnt + {{IDW{1'b0}}, w_acc} - {{IDW{1'b0}}, w_rel_ok};

  lowest_zero_onehot #(
    .N(N)
  ) u_lowest_zero (
    .i_vec   (w_busy_n),
    .o_onehot(w_low_oh)
  );

  onehot2bin #(
    .N  (N),
    .IDW(IDW)
  ) u_enc (
    .i_onehot(w_low_oh),
    .o_bin   (w_low_id)
  );

  // Occupancy bitmap and the counter with its registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_busy  <= w_busy_n;
      r_cnt   <= w_cnt_n;
      r_full  <= (w_cnt_n == FULL);
      r_empty <= (w_cnt_n == '0);
    end
  end

  // A pending offer stays frozen until taken, even if a lower slot frees up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_offer_v  <= 1'b0;
      r_offer_id <= '0;
    end else if (w_hold) begin
      r_offer_v  <= r_offer_v;
      r_offer_id <= r_offer_id;
    end else begin
      r_offer_v  <= w_any_free;
      r_offer_id <= w_low_id;
    end
  end

  // Sticky illegal-release flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (rel_valid & ~w_rel_ok) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign alloc_valid = r_offer_v;
  assign alloc_id    = r_offer_id;
  assign busy_cnt    = r_cnt;
  assign full        = r_full;
  assign empty       = r_empty;
  assign err         = r_err;

endmodule

// File: tb/tb_slot_freelist.sv
// Self-checking bench for slot_freelist: directed scenarios plus randomized
// traffic against a set-based reference model.
module tb_slot_freelist;
  import msm_slot_pkg::*;

  localparam int N   = SLOT_N;
  localparam int IDW = SLOT_IDW;

  logic           clk = 1'b0;
  logic           rst;
  logic           alloc_valid;
  logic [IDW-1:0] alloc_id;
  logic           alloc_ready;
  logic           rel_valid;
  slot_id_t       rel_id;
  logic [IDW:0]   busy_cnt;
  logic           full;
  logic           empty;
  logic           err;

  int errors = 0;
  int checks = 0;

  // Reference model: set of allocated IDs, the pending offer and the error flag.
  bit m_busy[N];
  bit m_offer_v  = 1'b0;
  int m_offer_id = 0;
  bit m_err      = 1'b0;

  slot_freelist #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_valid(alloc_valid),
    .alloc_id   (alloc_id),
    .alloc_ready(alloc_ready),
    .rel_valid  (rel_valid),
    .rel_id     (rel_id),
    .busy_cnt   (busy_cnt),
    .full       (full),
    .empty      (empty),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic int m_pop();
    int p = 0;
    for (int i = 0; i < N; i++) p += m_busy[i];
    return p;
  endfunction

  // Advance one clock and update the model from the inputs applied this cycle.
  task automatic cycle();
    bit nb[N];
    bit acc, rel_ok, nv, nerr;
    int nid;
    acc    = m_offer_v && alloc_ready;
    rel_ok = rel_valid && m_busy[rel_id];
    nb     = m_busy;
    if (acc) nb[m_offer_id] = 1'b1;
    if (rel_ok) nb[rel_id] = 1'b0;
    nerr = m_err || (rel_valid && !rel_ok);
    nv   = m_offer_v;
    nid  = m_offer_id;
    if (!(m_offer_v && !acc)) begin
      nv  = 1'b0;
      nid = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (!nb[i]) begin
          nv  = 1'b1;
          nid = i;
        end
      end
    end
    if (rst) begin
      nb   = '{default: 1'b0};
      nv   = 1'b0;
      nid  = 0;
      nerr = 1'b0;
    end
    @(posedge clk);
    #1;
    m_busy     = nb;
    m_offer_v  = nv;
    m_offer_id = nid;
    m_err      = nerr;
  endtask

  task automatic test_reset();
    rst = 1'b1; alloc_ready = 1'b0; rel_valid = 1'b0; rel_id = '0;
    cycle(); cycle();
    checks++;
    if ({alloc_valid, alloc_id, busy_cnt, full, empty, err} !==
        {1'b0, IDW'(0), (IDW+1)'(0), 1'b0, 1'b1, 1'b0})
      begin errors++; $display("FAIL reset_state: v=%0b id=%0d cnt=%0d full=%0b empty=%0b err=%0b, expected 0 0 0 0 1 0",
                               alloc_valid, alloc_id, busy_cnt, full, empty, err); end
    rst = 1'b0;
    cycle();
    checks++;
    if (alloc_valid !== 1'b1 || alloc_id !== IDW'(0))
      begin errors++; $display("FAIL first_offer: v=%0b id=%0d, expected 1 0", alloc_valid, alloc_id); end
  endtask

  task automatic test_fill();
    alloc_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (alloc_valid !== 1'b1 || alloc_id !== IDW'(i))
        begin errors++; $display("FAIL fill_seq: v=%0b id=%0d, expected 1 %0d", alloc_valid, alloc_id, i); end
      cycle();
    end
    alloc_ready = 1'b0;
    checks++;
    if (alloc_valid !== 1'b0 || full !== 1'b1 || busy_cnt !== (IDW+1)'(N) || empty !== 1'b0)
      begin errors++; $display("FAIL fill_full: v=%0b full=%0b cnt=%0d empty=%0b, expected 0 1 %0d 0",
                               alloc_valid, full, busy_cnt, empty, N); end
  endtask

  task automatic test_release_from_full();
    rel_valid = 1'b1; rel_id = IDW'(5);
    cycle();
    rel_valid = 1'b0;
    checks++;
    if (alloc_valid !== 1'b1 || alloc_id !== IDW'(5) || busy_cnt !== (IDW+1)'(N-1) || full !== 1'b0)
      begin errors++; $display("FAIL full_release: v=%0b id=%0d cnt=%0d full=%0b, expected 1 5 %0d 0",
                               alloc_valid, alloc_id, busy_cnt, full, N-1); end
    alloc_ready = 1'b1;
    cycle();
    alloc_ready = 1'b0;
    checks++;
    if (full !== 1'b1 || busy_cnt !== (IDW+1)'(N))
      begin errors++; $display("FAIL refill_5: full=%0b cnt=%0d, expected 1 %0d", full, busy_cnt, N); end
  endtask

  task automatic test_held_offer();
    rel_valid = 1'b1; rel_id = IDW'(3);
    cycle();
    rel_id = IDW'(1);
    cycle();
    rel_valid = 1'b0;
    checks++;
    if (alloc_valid !== 1'b1 || alloc_id !== IDW'(3) || busy_cnt !== (IDW+1)'(N-2))
      begin errors++; $display("FAIL held_offer: v=%0b id=%0d cnt=%0d, expected 1 3 %0d",
                               alloc_valid, alloc_id, busy_cnt, N-2); end
    cycle();
    checks++;
    if (alloc_id !== IDW'(3))
      begin errors++; $display("FAIL held_stable: id=%0d, expected 3", alloc_id); end
    alloc_ready = 1'b1;
    cycle();
    alloc_ready = 1'b0;
    checks++;
    if (alloc_valid !== 1'b1 || alloc_id !== IDW'(1) || busy_cnt !== (IDW+1)'(N-1))
      begin errors++; $display("FAIL after_held: v=%0b id=%0d cnt=%0d, expected 1 1 %0d",
                               alloc_valid, alloc_id, busy_cnt, N-1); end
    alloc_ready = 1'b1;
    cycle();
    alloc_ready = 1'b0;
  endtask

  task automatic test_accept_and_release();
    rel_valid = 1'b1; rel_id = IDW'(7);
    cycle();
    checks++;
    if (alloc_id !== IDW'(7) || busy_cnt !== (IDW+1)'(N-1))
      begin errors++; $display("FAIL offer_7: id=%0d cnt=%0d, expected 7 %0d", alloc_id, busy_cnt, N-1); end
    alloc_ready = 1'b1; rel_id = IDW'(2);
    cycle();
    alloc_ready = 1'b0; rel_valid = 1'b0;
    checks++;
    if (busy_cnt !== (IDW+1)'(N-1) || alloc_valid !== 1'b1 || alloc_id !== IDW'(2) || err !== 1'b0)
      begin errors++; $display("FAIL acc_rel: cnt=%0d v=%0b id=%0d err=%0b, expected %0d 1 2 0",
                               busy_cnt, alloc_valid, alloc_id, err, N-1); end
    alloc_ready = 1'b1;
    cycle();
    alloc_ready = 1'b0;
    checks++;
    if (full !== 1'b1)
      begin errors++; $display("FAIL refill_2: full=%0b, expected 1", full); end
  endtask

  task automatic test_illegal();
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    rel_valid = 1'b1; rel_id = IDW'(0);
    cycle();
    rel_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy_cnt !== (IDW+1)'(0) || alloc_valid !== 1'b1 || alloc_id !== IDW'(0))
      begin errors++; $display("FAIL rel_offered: err=%0b cnt=%0d v=%0b id=%0d, expected 1 0 1 0",
                               err, busy_cnt, alloc_valid, alloc_id); end
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    checks++;
    if (err !== 1'b0)
      begin errors++; $display("FAIL err_clear: err=%0b, expected 0", err); end
    alloc_ready = 1'b1;
    cycle(); cycle(); cycle();
    alloc_ready = 1'b0;
    rel_valid = 1'b1; rel_id = IDW'(9);
    cycle();
    rel_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy_cnt !== (IDW+1)'(3) || alloc_id !== IDW'(3))
      begin errors++; $display("FAIL rel_never: err=%0b cnt=%0d id=%0d, expected 1 3 3", err, busy_cnt, alloc_id); end
    cycle(); cycle(); cycle();
    checks++;
    if (err !== 1'b1)
      begin errors++; $display("FAIL err_sticky: err=%0b, expected 1", err); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    alloc_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    alloc_ready = 1'b0;
    rel_valid = 1'b1; rel_id = IDW'(12);
    cycle();
    checks++;
    if (busy_cnt !== (IDW+1)'(10) || err !== 1'b1)
      begin errors++; $display("FAIL ten_busy: cnt=%0d err=%0b, expected 10 1", busy_cnt, err); end
    rst = 1'b1; alloc_ready = 1'b1; rel_id = IDW'(4);
    cycle();
    rst = 1'b0; alloc_ready = 1'b0; rel_valid = 1'b0;
    checks++;
    if (busy_cnt !== (IDW+1)'(0) || empty !== 1'b1 || err !== 1'b0 || alloc_valid !== 1'b0 || full !== 1'b0)
      begin errors++; $display("FAIL mid_reset: cnt=%0d empty=%0b err=%0b v=%0b full=%0b, expected 0 1 0 0 0",
                               busy_cnt, empty, err, alloc_valid, full); end
    cycle();
    checks++;
    if (alloc_valid !== 1'b1 || alloc_id !== IDW'(0))
      begin errors++; $display("FAIL post_reset: v=%0b id=%0d, expected 1 0", alloc_valid, alloc_id); end
  endtask

  task automatic test_random();
    logic [2*IDW+4:0] got_v, exp_v;
    int q[$];
    int p;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      alloc_ready = ($urandom_range(0, 3) != 0);
      rel_valid   = ($urandom_range(0, 2) == 0);
      q.delete();
      for (int i = 0; i < N; i++) if (m_busy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 9) != 0)
        rel_id = IDW'(q[$urandom_range(0, q.size() - 1)]);
      else
        rel_id = IDW'($urandom_range(0, N - 1));
      cycle();
      p     = m_pop();
      exp_v = {m_offer_v, IDW'(m_offer_id), (IDW+1)'(p), (p == N), (p == 0), m_err};
      got_v = {alloc_valid, alloc_id, busy_cnt, full, empty, err};
      checks++;
      if (got_v !== exp_v)
        begin errors++; $display("FAIL random_c%0d: got {v,id,cnt,full,empty,err}=%h, expected %h", c, got_v, exp_v); end
    end
    rst = 1'b0; alloc_ready = 1'b0; rel_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release_from_full();
    test_held_offer();
    test_accept_and_release();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
